fft_band_level: RTL and testbench

Downstream consumer of the 1024-point FFT output stream. Takes the per-bin squared magnitude and bin counter, folds bins 1..512 into BAND_NUM equal-width frequency bands (per-band maximum), and converts each band maximum to a log2-scaled bar height. Once per FFT frame it presents a packed level vector to the WS2812 spectrum renderer.

---
 rtl/fft_band_level.sv | 182 ++++++++++++++++++
 tb/tb_fft_band_level.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fft_band_level.sv
// Folds FFT bins 1..512 into BAND_NUM bands (per-band peak) and converts each peak to a log2 bar height.
// Optional FFT_PEAK_DECAY_EN keeps a per-band held level so bars fall by at most one step per frame.
module fft_band_level #(
    parameter int BAND_NUM   = 8,
    parameter int BAND_SHIFT = 6,
    parameter int LEVEL_BASE = 16,
    parameter int LEVEL_MAX  = 8
) (
    input  logic                    data_in_clk,
    input  logic                    rst_n,
    input  logic [10:0]             fft_data_cnt,
    input  logic [63:0]             fft_data_amp,
    output logic [BAND_NUM*4-1:0]   band_level,
    output logic                    band_valid,
    output logic                    busy
);

    localparam int BAND_W = $clog2(BAND_NUM);
    localparam int IDX_W  = $clog2(BAND_NUM + 1);
    localparam int CNT_HI = (BAND_NUM << BAND_SHIFT) + 1;

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_CONV  = 2'd2;

    logic [10:0]            s1_cnt_q;
    logic [63:0]            s1_amp_q;
    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [63:0]            acc_q  [BAND_NUM];
    logic [63:0]            snap_q [BAND_NUM];
    logic [3:0]             stage_q [BAND_NUM];
    logic [3:0]             out_lvl [BAND_NUM];
    logic [BAND_NUM*4-1:0]  band_level_q, band_level_d;
    logic                   band_valid_q;

    logic                   s1_dc, s1_last, s1_in_range, frame_close, publish, conv_step;
    logic [BAND_W-1:0]      s1_band;
    logic [3:0]             conv_level;

    function automatic logic [3:0] amp_to_level(input logic [63:0] a);
        int m;
        int lvl;
        m = 0;
        for (int i = 0; i < 64; i++) begin
            if (a[i]) m = i;
        end
        if (a < (64'd1 << LEVEL_BASE)) begin
            lvl = 0;
        end else begin
            lvl = m - LEVEL_BASE + 1;
            if (lvl > LEVEL_MAX) lvl = LEVEL_MAX;
        end
        return 4'(lvl);
    endfunction

    always_ff @(posedge data_in_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cnt_q <= '0;
            s1_amp_q <= '0;
        end else begin
            s1_cnt_q <= fft_data_cnt;
            s1_amp_q <= fft_data_amp;
        end
    end

    assign s1_dc       = (s1_cnt_q == 11'd1);
    assign s1_last     = (s1_cnt_q == 11'd1024);
    assign s1_in_range = (s1_cnt_q >= 11'd2) && (s1_cnt_q <= 11'(CNT_HI));
    assign s1_band     = BAND_W'((s1_cnt_q - 11'd2) >> BAND_SHIFT);
    assign frame_close = (state_q == S_ACCUM) && s1_last;
    assign conv_step   = (state_q == S_CONV) && (idx_q != IDX_W'(BAND_NUM));
    assign conv_level  = amp_to_level(snap_q[idx_q[BAND_W-1:0]]);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        publish = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (s1_dc) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (s1_last) begin
                    state_d = S_CONV;
                    idx_d   = '0;
                end
            end
            S_CONV: begin
                if (idx_q == IDX_W'(BAND_NUM)) begin
                    state_d = S_ACCUM;
                    publish = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge data_in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the band arrays are few, small flops with defined reset values, so they are reset like any register.
    always_ff @(posedge data_in_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BAND_NUM; i++) acc_q[i] <= '0;
        end else if (s1_dc) begin
            for (int i = 0; i < BAND_NUM; i++) acc_q[i] <= '0;
        end else if ((state_q != S_WAIT) && s1_in_range && (s1_amp_q > acc_q[s1_band])) begin
            acc_q[s1_band] <= s1_amp_q;
        end
    end

    // Snapshot decouples conversion from accumulation so the next frame can start immediately.
    always_ff @(posedge data_in_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BAND_NUM; i++) snap_q[i] <= '0;
        end else if (frame_close) begin
            for (int i = 0; i < BAND_NUM; i++) snap_q[i] <= acc_q[i];
        end
    end

    always_ff @(posedge data_in_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BAND_NUM; i++) stage_q[i] <= '0;
        end else if (conv_step) begin
            stage_q[idx_q[BAND_W-1:0]] <= conv_level;
        end
    end

`ifdef FFT_PEAK_DECAY_EN
    logic [3:0] held_q [BAND_NUM];

    always_comb begin
        for (int k = 0; k < BAND_NUM; k++) begin
            out_lvl[k] = (held_q[k] == 4'd0) ? 4'd0 : held_q[k] - 4'd1;
            if (stage_q[k] > out_lvl[k]) out_lvl[k] = stage_q[k];
        end
    end

    always_ff @(posedge data_in_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BAND_NUM; k++) held_q[k] <= '0;
        end else if (publish) begin
            for (int k = 0; k < BAND_NUM; k++) held_q[k] <= out_lvl[k];
        end
    end
`else
    always_comb begin
        for (int k = 0; k < BAND_NUM; k++) out_lvl[k] = stage_q[k];
    end
`endif

    always_comb begin
        band_level_d = '0;
        for (int k = 0; k < BAND_NUM; k++) band_level_d[4*k +: 4] = out_lvl[k];
    end

    always_ff @(posedge data_in_clk or negedge rst_n) begin
        if (!rst_n) begin
            band_level_q <= '0;
            band_valid_q <= 1'b0;
        end else begin
            band_valid_q <= publish;
            if (publish) band_level_q <= band_level_d;
        end
    end

    assign band_level = band_level_q;
    assign band_valid = band_valid_q;
    assign busy       = (state_q == S_CONV);

endmodule

// File: tb/tb_fft_band_level.sv
// Directed bench for fft_band_level: full 1024-bin frames with hand-computed band levels and output timing.
module tb_fft_band_level;

    logic        clk;
    logic        rst_n;
    logic [10:0] cnt;
    logic [63:0] amp;
    logic [31:0] band_level;
    logic        band_valid;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] amp_tab [0:1024];
    logic [31:0] held_m;

    fft_band_level dut (
        .data_in_clk  (clk),
        .rst_n        (rst_n),
        .fft_data_cnt (cnt),
        .fft_data_amp (amp),
        .band_level   (band_level),
        .band_valid   (band_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_tab();
        for (int c = 0; c <= 1024; c++) amp_tab[c] = 64'd0;
    endtask

    task automatic drive_frame();
        for (int c = 1; c <= 1024; c++) begin
            @(negedge clk);
            cnt = 11'(c);
            amp = amp_tab[c];
        end
    endtask

    // j counts negedges after the edge that registered cnt 1024 (j = 0 follows E0).
    task automatic watch(output int lat, output int pulses, output logic [31:0] busy_tr);
        lat = -1;
        pulses = 0;
        busy_tr = '0;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            if (j == 0) begin
                cnt = 11'd0;
                amp = 64'd0;
            end
            busy_tr[j] = busy;
            if (band_valid) begin
                pulses++;
                if (lat < 0) lat = j;
            end
        end
    endtask

    task automatic model_out(input logic [31:0] new_vec, output logic [31:0] exp);
        exp = new_vec;
`ifdef FFT_PEAK_DECAY_EN
        for (int k = 0; k < 8; k++) begin
            logic [3:0] d;
            d = (held_m[4*k +: 4] == 4'd0) ? 4'd0 : held_m[4*k +: 4] - 4'd1;
            exp[4*k +: 4] = (new_vec[4*k +: 4] > d) ? new_vec[4*k +: 4] : d;
        end
`endif
        held_m = exp;
    endtask

    task automatic run_frame(input string tag, input logic [31:0] new_vec);
        int lat, pulses;
        logic [31:0] btr, exp;
        drive_frame();
        watch(lat, pulses, btr);
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'd10);
        model_out(new_vec, exp);
        check({tag, "_level"}, 64'(band_level), 64'(exp));
    endtask

    initial begin
        int lat, pulses;
        logic [31:0] btr, exp;
        logic [3:0] b3_exp [4];
`ifdef FFT_PEAK_DECAY_EN
        b3_exp = '{4'd7, 4'd6, 4'd5, 4'd4};
`else
        b3_exp = '{4'd7, 4'd0, 4'd0, 4'd0};
`endif
        rst_n = 1'b0;
        cnt = 11'd0;
        amp = 64'd0;
        held_m = '0;
        clear_tab();
        repeat (3) @(negedge clk);
        check("rst_level", 64'(band_level), 64'd0);
        check("rst_valid", 64'(band_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Close marker before any frame start must not produce output.
        @(negedge clk);
        cnt = 11'd1024;
        watch(lat, pulses, btr);
        check("nostart_pulses", 64'(pulses), 64'd0);
        check("nostart_busy", 64'(btr[23:0]), 64'd0);

        // All-zero frame: timing and busy window.
        drive_frame();
        watch(lat, pulses, btr);
        check("zero_pulses", 64'(pulses), 64'd1);
        check("zero_latency", 64'(lat), 64'd10);
        check("zero_busy", 64'(btr[23:0]), 64'h0003FE);
        model_out(32'h0, exp);
        check("zero_level", 64'(band_level), 64'(exp));

        // Bin 1 -> 5; band 5 peak 2^18 -> 3; band 6 2^16-1 -> 0; last bin 2^16 -> 1.
        clear_tab();
        amp_tab[2]   = 64'd1 << 20;
        amp_tab[330] = 64'd1 << 18;
        amp_tab[340] = (64'd1 << 18) - 64'd1;
        amp_tab[400] = (64'd1 << 16) - 64'd1;
        amp_tab[513] = 64'd1 << 16;
        run_frame("mix", 32'h1030_0005);

        // Clamp at band 0 edge; cnt 514 lies outside the band range.
        clear_tab();
        amp_tab[65]  = 64'd1 << 40;
        amp_tab[514] = 64'd1 << 40;
        run_frame("clamp", 32'h0000_0008);

        // DC only.
        clear_tab();
        amp_tab[1] = 64'h8000_0000_0000_0000;
        run_frame("dc", 32'h0000_0000);

        // Band 3 = 7, then three silent frames.
        clear_tab();
        amp_tab[200] = 64'd1 << 22;
        for (int f = 0; f < 4; f++) begin
            run_frame($sformatf("decay%0d", f), (f == 0) ? 32'h0000_7000 : 32'h0);
            check($sformatf("decay%0d_b3", f), 64'(band_level[15:12]), 64'(b3_exp[f]));
            clear_tab();
        end

        // Reset during conversion: pending result discarded.
        amp_tab[2] = 64'd1 << 20;
        drive_frame();
        repeat (4) @(negedge clk);
        cnt = 11'd0;
        amp = 64'd0;
        rst_n = 1'b0;
        held_m = '0;
        repeat (2) @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (band_valid) pulses++;
        end
        check("midrst_pulses", 64'(pulses), 64'd0);
        check("midrst_level", 64'(band_level), 64'd0);
        run_frame("after_rst", 32'h0000_0005);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
